wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Two-master, one-slave Wishbone-classic arbiter. It lets the core's instruction-fetch port and data port share the single `core_*` memory bus when `ENABLE_SECOND_MEMORY` is not defined. It sits in `processorci_top`, between the core and the Controller (or the simulation memory model). It applies round-robin arbitration, locks the grant for the whole transaction, and has a per-transaction ack timeout so a dead slave cannot hang the core.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width of all ports.
- `DATA_WIDTH`, 32, data width; wstrb width is `DATA_WIDTH/8`.
- `TIMEOUT_CYCLES`, 255, cycles in BUSY before abort with error; 0 disables the timeout.

Ports:
- `sys_clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `i_cyc`, `i_stb`  in  1  instruction master request (read-only).
- `i_addr`  in  ADDR_WIDTH  instruction address.
- `i_rdata`  out  DATA_WIDTH  fetch data to core.
- `i_ack`, `i_err`  out  1  instruction completion / timeout error.
- `d_cyc`, `d_stb`, `d_we`  in  1  data master request.
- `d_wstrb`  in  DATA_WIDTH/8  byte enables.
- `d_addr`  in  ADDR_WIDTH  data address.
- `d_wdata`  in  DATA_WIDTH  write data.
- `d_rdata`  out  DATA_WIDTH  load data.
- `d_ack`, `d_err`  out  1  data completion / timeout error.
- `m_cyc`, `m_stb`, `m_we`  out  1  shared-bus request.
- `m_wstrb`  out  DATA_WIDTH/8  shared-bus byte enables.
- `m_addr`  out  ADDR_WIDTH  shared-bus address.
- `m_wdata`  out  DATA_WIDTH  shared-bus write data.
- `m_rdata`  in  DATA_WIDTH  shared-bus read data.
- `m_ack`  in  1  shared-bus acknowledge.

## Operation
- A request is `x_cyc & x_stb`. Masters hold their request stable until ack/err (Wishbone classic).
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - One requester → go to its BUSY state.
  - Both requesting → grant the master not in `last_grant`, then update `last_grant`.
  - On grant, latch that master's addr, we, wstrb and wdata into the `m_*` output registers.
- BUSY_I drives `m_we=0` and `m_wstrb=0` unconditionally.
- BUSY_x with `m_ack=1`:
  - Pulse `x_ack` combinationally in the same cycle.
  - `x_rdata = m_rdata`.
  - Next state IDLE; `m_cyc`/`m_stb` deassert.
- BUSY_x with granted `x_cyc` low (master abort): next state IDLE, no ack or err forwarded, `m_cyc` drops.
- Timeout:
  - The counter clears on grant and increments each BUSY cycle without ack.
  - When count == `TIMEOUT_CYCLES-1` with no ack: pulse `x_err` for one cycle, then go to IDLE.
  - Ack in the same cycle as timeout: ack wins, no err.
- `m_ack` seen in IDLE is ignored. The non-granted master's ack, err and rdata stay 0.
- Simultaneous abort and `m_ack`: abort wins, no ack forwarded.

## Timing
- Reset values (rst_n low at an edge):
  - State IDLE.
  - All `m_*` outputs 0.
  - `i_ack`, `i_err`, `d_ack`, `d_err` 0; `i_rdata`, `d_rdata` 0.
  - Counter 0.
  - `last_grant = D`, so instruction wins the first tie.
- Reset mid-transaction aborts silently and nothing is forwarded.
- Latency:
  - Request seen in IDLE at cycle N → `m_cyc=1` at N+1.
  - Zero-wait slave acks at N+1 → master ack at N+1 → IDLE at N+2.
  - Peak throughput is one transfer per 2 cycles.
- `m_addr`, `m_we`, `m_wstrb` and `m_wdata` are registered and stable for the whole BUSY period.

## Structure
- Package `wb_arb_pkg`: `arb_state_t` enum (IDLE, BUSY_I, BUSY_D), `grant_t` enum (GRANT_I, GRANT_D), default width localparams.
- One sub-module, `arb_timeout_counter`: clear / enable / expired, parameterised by `TIMEOUT_CYCLES`; expired is tied 0 when the parameter is 0.

## Test plan
- **Reset then fetch:** reset for 3 cycles, all outputs 0. Then i read 0x0000_0100 with slave acking 2 cycles after `m_cyc` with 0xDEAD_BEEF → `i_ack` one cycle, `i_rdata=0xDEAD_BEEF`, `m_we=0`.
- **Fairness:** both masters request continuously from reset → grants I, D, I, D…; never two consecutive grants to one master while the other waits.
- **Data write:** `d_we=1`, `d_addr=0x8000_0004`, `d_wdata=0x1234_5678`, `d_wstrb=0011` → `m_*` match for the whole BUSY_D; instruction request stalls until `d_ack`.
- **Timeout:** `TIMEOUT_CYCLES=8`, slave never acks → `d_err` pulses on the 8th BUSY cycle, `m_cyc` drops next cycle, pending i request then granted. Separately, ack on the 8th cycle → `d_ack` only, no `d_err`.
- **Abort:** drop `i_cyc` in cycle 2 of BUSY_I → IDLE next cycle; a late `m_ack` in IDLE produces no `i_ack`.
- **Reset mid-transaction:** `rst_n` low during BUSY_D → next edge all outputs 0; first tie after release goes to I.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the two-master Wishbone-classic port arbiter.
// Latency: none (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   arb_state_t - arbiter FSM states (IDLE, BUSY_I, BUSY_D)
//   grant_t     - identity of the master that owns (or last owned) the bus
//   DEF_*       - default parameter values for the arbiter and its sub-blocks
//   cnt_width() - register width needed to count 0 .. cycles-1
package wb_arb_pkg;

  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  // The counter only ever needs to reach cycles-1. A zero or one cycle
  // budget still gets a 1-bit register so the port widths stay legal.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Per-transaction watchdog: counts busy cycles without an acknowledge.
// Latency: expired is a registered decode, valid in the cycle count reaches TIMEOUT_CYCLES-1.
// Backpressure: none; clear has priority over enable, expired is tied 0 when TIMEOUT_CYCLES == 0.
//
// Ports:
//   clk, rst_n - clock and synchronous active-low reset
//   clear      - restart from 0 (asserted on each new grant)
//   enable     - count this cycle (busy and no acknowledge)
//   expired    - count has reached TIMEOUT_CYCLES-1
module arb_timeout_counter
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW    = cnt_width(TIMEOUT_CYCLES);
  localparam int LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  logic [CW-1:0] count;

  // Wrap-around is harmless: the arbiter leaves BUSY in the cycle expired
  // is seen, and the next grant clears the count before it matters again.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      assign expired = 1'b0;
    end else begin : g_enabled
      assign expired = (count == CW'(LIMIT));
    end
  endgenerate

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing one Wishbone-classic slave between the fetch (i) and data (d) ports.
// Latency: request in IDLE at cycle N -> m_cyc at N+1; slave ack is returned to the master combinationally.
// Backpressure: grant is held for the whole transaction; the other master simply waits with its request up.
//
// Ports:
//   sys_clk, rst_n              - clock and synchronous active-low reset
//   i_cyc/i_stb/i_addr          - instruction-fetch request (read-only)
//   i_rdata/i_ack/i_err         - fetch response; err means the slave timed out
//   d_cyc/d_stb/d_we/d_wstrb/
//   d_addr/d_wdata              - data-port request
//   d_rdata/d_ack/d_err         - data response; err means the slave timed out
//   m_cyc/m_stb/m_we/m_wstrb/
//   m_addr/m_wdata              - registered shared-bus request, stable while busy
//   m_rdata/m_ack               - shared-bus response
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,

  input  logic                    i_cyc,
  input  logic                    i_stb,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_ack,
  output logic                    i_err,

  input  logic                    d_cyc,
  input  logic                    d_stb,
  input  logic                    d_we,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_ack,
  output logic                    d_err,

  output logic                    m_cyc,
  output logic                    m_stb,
  output logic                    m_we,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic                    m_ack
);

  arb_state_t state_q, state_d;
  grant_t     last_grant_q, last_grant_d;

  logic i_req, d_req;
  logic grant_i, grant_d;
  logic busy_i, busy_d;
  logic i_live, d_live;
  logic tmo_clear, tmo_enable, tmo_expired;

  assign i_req  = i_cyc & i_stb;
  assign d_req  = d_cyc & d_stb;
  assign busy_i = (state_q == BUSY_I);
  assign busy_d = (state_q == BUSY_D);

  // A transaction can only complete while its owner still holds cyc (an
  // abort beats a coincident ack) and while reset is released (a reset in
  // the middle of a transfer must not leak a stray ack or err).
  assign i_live = busy_i & i_cyc & rst_n;
  assign d_live = busy_d & d_cyc & rst_n;

  arb_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (sys_clk),
    .rst_n   (rst_n),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  // Next-state, grant decision and master-side responses.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    i_ack        = 1'b0;
    i_err        = 1'b0;
    d_ack        = 1'b0;
    d_err        = 1'b0;
    i_rdata      = '0;
    d_rdata      = '0;

    case (state_q)
      IDLE: begin
        // On a tie the master that did not win last time goes first.
        if (i_req && (!d_req || (last_grant_q == GRANT_D))) begin
          grant_i = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end

        if (grant_i) begin
          state_d      = BUSY_I;
          last_grant_d = GRANT_I;
        end else if (grant_d) begin
          state_d      = BUSY_D;
          last_grant_d = GRANT_D;
        end
      end

      BUSY_I: begin
        if (!i_cyc || m_ack || tmo_expired) begin
          state_d = IDLE;
        end
      end

      BUSY_D: begin
        if (!d_cyc || m_ack || tmo_expired) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Ack wins over a timeout landing in the same cycle.
    i_ack = i_live & m_ack;
    i_err = i_live & ~m_ack & tmo_expired;
    d_ack = d_live & m_ack;
    d_err = d_live & ~m_ack & tmo_expired;

    if (i_ack) begin
      i_rdata = m_rdata;
    end
    if (d_ack) begin
      d_rdata = m_rdata;
    end
  end

  assign tmo_clear  = grant_i | grant_d;
  assign tmo_enable = (busy_i | busy_d) & ~m_ack;

  // State, round-robin pointer and the registered shared-bus request.
  // The request fields are captured once at grant so they cannot change
  // under the slave, whatever the master does with its own bus meanwhile.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
      m_cyc        <= 1'b0;
      m_stb        <= 1'b0;
      m_we         <= 1'b0;
      m_wstrb      <= '0;
      m_addr       <= '0;
      m_wdata      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;

      if (grant_i) begin
        // Fetches are reads: no write enable or byte lanes on the bus.
        m_cyc   <= 1'b1;
        m_stb   <= 1'b1;
        m_we    <= 1'b0;
        m_wstrb <= '0;
        m_addr  <= i_addr;
        m_wdata <= '0;
      end else if (grant_d) begin
        m_cyc   <= 1'b1;
        m_stb   <= 1'b1;
        m_we    <= d_we;
        m_wstrb <= d_wstrb;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
      end else if (state_d == IDLE) begin
        m_cyc <= 1'b0;
        m_stb <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: per-cycle vector table plus a
// continuous two-master contention run with a response scoreboard.
module tb_wb_port_arbiter;

  localparam logic [31:0] IA  = 32'h0000_0100;
  localparam logic [31:0] DA  = 32'h8000_0004;
  localparam logic [31:0] DD  = 32'h1234_5678;
  localparam logic [3:0]  DS  = 4'b0011;
  localparam logic [31:0] KEY = 32'h5A5A_0000;

  localparam logic [1:0] MG_IDLE = 2'd0;
  localparam logic [1:0] MG_I    = 2'd1;
  localparam logic [1:0] MG_D    = 2'd2;
  localparam logic [1:0] MG_RST  = 2'd3;

  logic        sys_clk;
  logic        rst_n;
  logic        i_cyc, i_stb;
  logic [31:0] i_addr, i_rdata;
  logic        i_ack, i_err;
  logic        d_cyc, d_stb, d_we;
  logic [3:0]  d_wstrb;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_ack, d_err;
  logic        m_cyc, m_stb, m_we;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_ack;

  wb_port_arbiter #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .i_cyc   (i_cyc),
    .i_stb   (i_stb),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_ack   (i_ack),
    .i_err   (i_err),
    .d_cyc   (d_cyc),
    .d_stb   (d_stb),
    .d_we    (d_we),
    .d_wstrb (d_wstrb),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ack   (d_ack),
    .d_err   (d_err),
    .m_cyc   (m_cyc),
    .m_stb   (m_stb),
    .m_we    (m_we),
    .m_wstrb (m_wstrb),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ack   (m_ack)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // One row per clock cycle: inputs driven just after the rising edge,
  // outputs checked mid-cycle. mg names who should own the bus as seen on
  // the registered m_* outputs in that cycle (MG_RST = everything zero).
  typedef struct {
    logic        rst;
    logic        ic;
    logic        dc;
    logic        ma;
    logic [31:0] mr;
    logic [1:0]  mg;
    logic        ia;
    logic        ie;
    logic        da;
    logic        de;
  } vec_t;

  vec_t        vecs[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] iq[$];
  logic [31:0] dq[$];

  function automatic void add(input logic rst, input logic ic, input logic dc,
                              input logic ma, input logic [31:0] mr,
                              input logic [1:0] mg, input logic ia,
                              input logic ie, input logic da, input logic de);
    vec_t v;
    v.rst = rst; v.ic = ic; v.dc = dc; v.ma = ma; v.mr = mr;
    v.mg = mg; v.ia = ia; v.ie = ie; v.da = da; v.de = de;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string what, input int idx,
                     input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s @%0d: got %h, want %h", what, idx, got, want);
    end
  endtask

  task automatic check_row(input int k, input vec_t v);
    logic owned;
    owned = (v.mg == MG_I) || (v.mg == MG_D);
    chk("m_cyc", k, {31'd0, m_cyc}, {31'd0, owned});
    chk("m_stb", k, {31'd0, m_stb}, {31'd0, owned});
    chk("i_ack", k, {31'd0, i_ack}, {31'd0, v.ia});
    chk("i_err", k, {31'd0, i_err}, {31'd0, v.ie});
    chk("d_ack", k, {31'd0, d_ack}, {31'd0, v.da});
    chk("d_err", k, {31'd0, d_err}, {31'd0, v.de});
    if (v.mg == MG_I) begin
      chk("m_we(i)",    k, {31'd0, m_we},    32'd0);
      chk("m_wstrb(i)", k, {28'd0, m_wstrb}, 32'd0);
      chk("m_addr(i)",  k, m_addr,           IA);
      chk("d_rdata(i)", k, d_rdata,          32'd0);
    end
    if (v.mg == MG_D) begin
      chk("m_we(d)",    k, {31'd0, m_we},    32'd1);
      chk("m_wstrb(d)", k, {28'd0, m_wstrb}, {28'd0, DS});
      chk("m_addr(d)",  k, m_addr,           DA);
      chk("m_wdata(d)", k, m_wdata,          DD);
      chk("i_rdata(d)", k, i_rdata,          32'd0);
    end
    if (v.mg == MG_RST) begin
      chk("m_we(rst)",    k, {31'd0, m_we},    32'd0);
      chk("m_wstrb(rst)", k, {28'd0, m_wstrb}, 32'd0);
      chk("m_addr(rst)",  k, m_addr,           32'd0);
      chk("m_wdata(rst)", k, m_wdata,          32'd0);
      chk("i_rdata(rst)", k, i_rdata,          32'd0);
      chk("d_rdata(rst)", k, d_rdata,          32'd0);
    end
    if (v.ia) chk("i_rdata", k, i_rdata, v.mr);
    if (v.da) chk("d_rdata", k, d_rdata, v.mr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       i_got, d_got;
    logic       exp_who, who;
    int         i_cnt, d_cnt;
    logic [31:0] e;

    rst_n = 1'b0; i_cyc = 1'b0; i_stb = 1'b0; i_addr = IA;
    d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b1; d_wstrb = DS;
    d_addr = DA; d_wdata = DD; m_ack = 1'b0; m_rdata = '0;

    // Reset for three cycles, then a fetch acked two cycles after m_cyc.
    repeat (3) add(0, 0, 0, 0, 0, MG_RST, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0,              MG_RST, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0,              MG_I,   0, 0, 0, 0);
    add(1, 1, 0, 0, 0,              MG_I,   0, 0, 0, 0);
    add(1, 1, 0, 1, 32'hDEAD_BEEF,  MG_I,   1, 0, 0, 0);
    add(1, 0, 0, 0, 0,              MG_IDLE,0, 0, 0, 0);
    // Data write; fetch arrives while D is busy and must wait for d_ack.
    add(1, 0, 1, 0, 0,              MG_IDLE,0, 0, 0, 0);
    add(1, 1, 1, 0, 0,              MG_D,   0, 0, 0, 0);
    add(1, 1, 1, 0, 0,              MG_D,   0, 0, 0, 0);
    add(1, 1, 1, 1, 32'h5555_AAAA,  MG_D,   0, 0, 1, 0);
    add(1, 1, 0, 0, 0,              MG_IDLE,0, 0, 0, 0);
    add(1, 1, 0, 0, 0,              MG_I,   0, 0, 0, 0);
    add(1, 1, 0, 1, 32'hCAFE_0001,  MG_I,   1, 0, 0, 0);
    add(1, 0, 0, 0, 0,              MG_IDLE,0, 0, 0, 0);
    // Dead slave: d_err on the 8th busy cycle, pending fetch granted after.
    add(1, 0, 1, 0, 0,              MG_IDLE,0, 0, 0, 0);
    for (int c = 1; c < 8; c++) add(1, 1, 1, 0, 0, MG_D, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0,              MG_D,   0, 0, 0, 1);
    add(1, 1, 0, 0, 0,              MG_IDLE,0, 0, 0, 0);
    add(1, 1, 0, 0, 0,              MG_I,   0, 0, 0, 0);
    add(1, 1, 0, 1, 32'h0000_1111,  MG_I,   1, 0, 0, 0);
    add(1, 0, 0, 0, 0,              MG_IDLE,0, 0, 0, 0);
    // Ack on the 8th busy cycle beats the timeout.
    add(1, 0, 1, 0, 0,              MG_IDLE,0, 0, 0, 0);
    for (int c = 1; c < 8; c++) add(1, 0, 1, 0, 0, MG_D, 0, 0, 0, 0);
    add(1, 0, 1, 1, 32'h0BAD_F00D,  MG_D,   0, 0, 1, 0);
    add(1, 0, 0, 0, 0,              MG_IDLE,0, 0, 0, 0);
    // Fetch abort in busy cycle 2, then a late ack seen in IDLE.
    add(1, 1, 0, 0, 0,              MG_IDLE,0, 0, 0, 0);
    add(1, 1, 0, 0, 0,              MG_I,   0, 0, 0, 0);
    add(1, 0, 0, 0, 0,              MG_I,   0, 0, 0, 0);
    add(1, 0, 0, 1, 32'hFFFF_FFFF,  MG_IDLE,0, 0, 0, 0);
    // Abort coinciding with ack: nothing forwarded.
    add(1, 1, 0, 0, 0,              MG_IDLE,0, 0, 0, 0);
    add(1, 1, 0, 0, 0,              MG_I,   0, 0, 0, 0);
    add(1, 0, 0, 1, 32'h7777_7777,  MG_I,   0, 0, 0, 0);
    add(1, 0, 0, 0, 0,              MG_IDLE,0, 0, 0, 0);
    // Reset during BUSY_D with an ack present; first tie afterwards goes to I.
    add(1, 0, 1, 0, 0,              MG_IDLE,0, 0, 0, 0);
    add(1, 0, 1, 0, 0,              MG_D,   0, 0, 0, 0);
    add(0, 0, 1, 1, 32'h3333_3333,  MG_D,   0, 0, 0, 0);
    add(1, 1, 1, 0, 0,              MG_RST, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0,              MG_I,   0, 0, 0, 0);
    add(1, 1, 1, 1, 32'h4444_0000,  MG_I,   1, 0, 0, 0);
    add(1, 0, 1, 0, 0,              MG_IDLE,0, 0, 0, 0);
    add(1, 0, 1, 1, 32'h4444_0001,  MG_D,   0, 0, 1, 0);
    add(1, 0, 0, 0, 0,              MG_IDLE,0, 0, 0, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      @(posedge sys_clk); #1;
      rst_n   = vecs[k].rst;
      i_cyc   = vecs[k].ic;
      i_stb   = vecs[k].ic;
      d_cyc   = vecs[k].dc;
      d_stb   = vecs[k].dc;
      m_ack   = vecs[k].ma;
      m_rdata = vecs[k].mr;
      #4;
      check_row(k, vecs[k]);
    end

    // Both masters read back-to-back from reset against a zero-wait slave
    // that returns addr ^ KEY. Grants must alternate I, D, I, D ...
    @(posedge sys_clk); #1;
    rst_n = 1'b0; m_ack = 1'b0; m_rdata = '0;
    i_cyc = 1'b1; i_stb = 1'b1; i_addr = 32'h0000_1000;
    d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b0; d_wstrb = 4'b0000;
    d_addr = 32'h0000_2000; d_wdata = '0;
    iq.push_back(i_addr);
    dq.push_back(d_addr);
    repeat (2) @(posedge sys_clk);

    i_got = 1'b0; d_got = 1'b0; exp_who = 1'b0; i_cnt = 0; d_cnt = 0;
    for (int it = 0; it < 40; it++) begin
      @(posedge sys_clk); #1;
      rst_n = 1'b1;
      if (i_got) begin
        i_addr = i_addr + 32'd4;
        iq.push_back(i_addr);
      end
      if (d_got) begin
        d_addr = d_addr + 32'd4;
        dq.push_back(d_addr);
      end
      m_ack   = m_cyc;
      m_rdata = m_addr ^ KEY;
      if (m_cyc) begin
        who = m_addr[13];
        chk("grant_order", it, {31'd0, who}, {31'd0, exp_who});
        exp_who = ~exp_who;
      end
      #4;
      i_got = i_ack;
      d_got = d_ack;
      chk("rr_errs", it, {30'd0, i_err, d_err}, 32'd0);
      if (i_ack) begin
        i_cnt++;
        if (iq.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL i_scoreboard @%0d: got ack, want none outstanding", it);
        end else begin
          e = iq.pop_front();
          chk("rr_i_rdata", it, i_rdata, e ^ KEY);
        end
      end
      if (d_ack) begin
        d_cnt++;
        if (dq.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL d_scoreboard @%0d: got ack, want none outstanding", it);
        end else begin
          e = dq.pop_front();
          chk("rr_d_rdata", it, d_rdata, e ^ KEY);
        end
      end
    end
    chk("rr_i_count", 0, i_cnt, 32'd10);
    chk("rr_d_count", 0, d_cnt, 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
